// File: rtl/packet_framer.sv
// ---------------------------------------------------------------------------
// packet_framer
//   Buffers 32-bit source words in a small FIFO and emits them downstream as
//   packets of pkt_len words. The first word is marked with start_of_packet
//   and the last with end_of_packet. Every packet is followed by one gap cycle.
//   Source bubbles inside a packet are counted as underruns.
//
// Ports
//   clk             : single clock, rising edge
//   rst             : asynchronous active-high reset
//   in_valid        : source offers in_data
//   in_data  [31:0] : source word
//   in_ready        : FIFO not full; a word is accepted when in_valid & in_ready
//   enable          : permits a new packet to start
//   pkt_len  [3:0]  : payload words per packet (1..15), sampled at packet start
//   data_valid      : qualifies packet_data_out (registered)
//   packet_data_out : downstream word (registered, holds when not valid)
//   start_of_packet : first word of a packet (registered)
//   end_of_packet   : last word of a packet (registered)
//   busy            : state machine is in SEND or GAP
//   packet_count    : packets emitted, wraps at 256
//   underrun_count  : mid-packet bubble cycles, saturates at 15
// ---------------------------------------------------------------------------
module packet_framer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        enable,
  input  logic [3:0]  pkt_len,
  output logic        data_valid,
  output logic [31:0] packet_data_out,
  output logic        start_of_packet,
  output logic        end_of_packet,
  output logic        busy,
  output logic [7:0]  packet_count,
  output logic [3:0]  underrun_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_FILL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state, state_d;

  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fill;
  logic              full, empty, push, pop;

  logic [3:0]        len_q, len_d;
  logic [3:0]        idx, idx_d;
  logic              sop_d, eop_d, under_inc;

  // -------------------------------------------------------------------------
  // Input FIFO
  // -------------------------------------------------------------------------
  assign full     = (fill == FULL_FILL);
  assign empty    = (fill == '0);
  assign in_ready = ~full;
  // in_ready is low whenever full, so a same-cycle pop never frees room for
  // a write; the write is simply refused.
  assign push     = in_valid & in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array is not reset; entries are only read after being
  // written, and the pointers/fill count that define validity are reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // -------------------------------------------------------------------------
  // Framing state machine
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    len_d     = len_q;
    idx_d     = idx;
    pop       = 1'b0;
    sop_d     = 1'b0;
    eop_d     = 1'b0;
    under_inc = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !empty && pkt_len != 4'd0) begin
          pop     = 1'b1;
          sop_d   = 1'b1;
          len_d   = pkt_len;
          idx_d   = 4'd1;
          // A one-word packet starts and ends on the same word.
          eop_d   = (pkt_len == 4'd1);
          state_d = eop_d ? GAP : SEND;
        end
      end
      SEND: begin
        if (!empty) begin
          pop     = 1'b1;
          idx_d   = idx + 4'd1;
          // idx is the index of the word being emitted now.
          eop_d   = (idx == len_q - 4'd1);
          state_d = eop_d ? GAP : SEND;
        end else begin
          under_inc = 1'b1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      len_q           <= '0;
      idx             <= '0;
      data_valid      <= 1'b0;
      start_of_packet <= 1'b0;
      end_of_packet   <= 1'b0;
      packet_data_out <= '0;
      packet_count    <= '0;
      underrun_count  <= '0;
    end else begin
      state           <= state_d;
      len_q           <= len_d;
      idx             <= idx_d;
      data_valid      <= pop;
      start_of_packet <= sop_d;
      end_of_packet   <= eop_d;
      if (pop)   packet_data_out <= mem[rd_ptr];
      if (eop_d) packet_count    <= packet_count + 8'd1;
      if (under_inc && underrun_count != 4'hF)
        underrun_count <= underrun_count + 4'd1;
    end
  end

  assign busy = (state == SEND) || (state == GAP);

endmodule

// File: tb/tb_packet_framer.sv
// ---------------------------------------------------------------------------
// tb_packet_framer
//   Self-checking bench for packet_framer. Directed vector tables, a few
//   hand-written multi-cycle sequences and a randomized run are all compared
//   every cycle against a packet-level reference model (word queue plus a
//   "words remaining" count and a gap flag).
// ---------------------------------------------------------------------------
module tb_packet_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        enable = 1'b0;
  logic [3:0]  pkt_len = '0;
  logic        data_valid;
  logic [31:0] packet_data_out;
  logic        start_of_packet;
  logic        end_of_packet;
  logic        busy;
  logic [7:0]  packet_count;
  logic [3:0]  underrun_count;

  packet_framer #(.FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .enable          (enable),
    .pkt_len         (pkt_len),
    .data_valid      (data_valid),
    .packet_data_out (packet_data_out),
    .start_of_packet (start_of_packet),
    .end_of_packet   (end_of_packet),
    .busy            (busy),
    .packet_count    (packet_count),
    .underrun_count  (underrun_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: packet-level view of the framer
  // -------------------------------------------------------------------------
  logic [31:0] m_q[$];
  int          m_remaining;
  bit          m_gap;
  bit          m_dv, m_sop, m_eop;
  logic [31:0] m_data;
  logic [7:0]  m_cnt;
  int          m_under;

  task automatic model_reset();
    m_q.delete();
    m_remaining = 0;
    m_gap       = 0;
    m_dv        = 0;
    m_sop       = 0;
    m_eop       = 0;
    m_data      = '0;
    m_cnt       = '0;
    m_under     = 0;
  endtask

  // One clock edge, evaluated on the inputs the DUT saw at that edge.
  task automatic model_edge();
    int sz = m_q.size();
    bit acc = in_valid && (sz < 4);
    m_dv  = 0;
    m_sop = 0;
    m_eop = 0;
    if (m_gap) begin
      m_gap = 0;
    end else if (m_remaining > 0) begin
      if (sz > 0) begin
        m_dv = 1;
        m_remaining--;
        m_eop = (m_remaining == 0);
      end else if (m_under < 15) begin
        m_under++;
      end
    end else if (enable && sz > 0 && pkt_len != 0) begin
      m_dv  = 1;
      m_sop = 1;
      m_remaining = int'(pkt_len) - 1;
      m_eop = (m_remaining == 0);
    end
    if (m_dv) m_data = m_q.pop_front();
    if (m_eop) begin
      m_gap = 1;
      m_cnt = m_cnt + 8'd1;
    end
    if (acc) m_q.push_back(in_data);
  endtask

  task automatic compare_model();
    check("in_ready",        in_ready,        (m_q.size() < 4));
    check("data_valid",      data_valid,      m_dv);
    check("start_of_packet", start_of_packet, m_sop);
    check("end_of_packet",   end_of_packet,   m_eop);
    check("packet_data_out", packet_data_out, m_data);
    check("busy",            busy,            (m_remaining > 0) || m_gap);
    check("packet_count",    packet_count,    m_cnt);
    check("underrun_count",  underrun_count,  m_under);
  endtask

  // Drive one cycle of inputs, take the edge, then compare 1 time unit later.
  task automatic step(input logic v, input logic [31:0] d, input logic en, input logic [3:0] len);
    in_valid = v;
    in_data  = d;
    enable   = en;
    pkt_len  = len;
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic apply_reset(input bit chk);
    rst      = 1'b1;
    in_valid = 1'b0;
    enable   = 1'b0;
    pkt_len  = '0;
    in_data  = '0;
    #1;
    if (chk) begin
      check("rst_data_valid", data_valid,      1'b0);
      check("rst_sop",        start_of_packet, 1'b0);
      check("rst_eop",        end_of_packet,   1'b0);
      check("rst_data",       packet_data_out, 32'd0);
      check("rst_busy",       busy,            1'b0);
      check("rst_in_ready",   in_ready,        1'b1);
      check("rst_count",      packet_count,    8'd0);
      check("rst_underrun",   underrun_count,  4'd0);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      if (chk) check("rst_hold_no_eop", end_of_packet, 1'b0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  // -------------------------------------------------------------------------
  // Directed vector table
  // -------------------------------------------------------------------------
  typedef struct {
    bit          do_reset;
    bit          v;
    logic [31:0] d;
    bit          en;
    logic [3:0]  len;
    logic [3:0]  e_flags;   // {data_valid, sop, eop, busy}
    logic [31:0] e_data;
    logic [7:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(bit r, bit v, logic [31:0] d, bit en, logic [3:0] len,
                              logic [3:0] fl, logic [31:0] ed, logic [7:0] ec);
    vec_t t;
    t.do_reset = r;  t.v = v;  t.d = d;  t.en = en;  t.len = len;
    t.e_flags = fl;  t.e_data = ed;  t.e_cnt = ec;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    int          sent;
    int          bubbles;
    int          n_dv, n_sop, n_eop;
    int          dut_eops;
    bit          done, in_pkt, acc;
    logic [3:0]  len_r;
    logic [31:0] got[$];

    // Basic 4-word packet, words 0x11..0x14 back-to-back.
    tbl.push_back(mk(1, 1, 32'h11, 1, 4, 4'b0000, 32'h00, 8'd0));
    tbl.push_back(mk(0, 1, 32'h12, 1, 4, 4'b1101, 32'h11, 8'd0));
    tbl.push_back(mk(0, 1, 32'h13, 1, 4, 4'b1001, 32'h12, 8'd0));
    tbl.push_back(mk(0, 1, 32'h14, 1, 4, 4'b1001, 32'h13, 8'd0));
    tbl.push_back(mk(0, 0, 32'h00, 1, 4, 4'b1011, 32'h14, 8'd1));
    tbl.push_back(mk(0, 0, 32'h00, 1, 4, 4'b0000, 32'h14, 8'd1));
    // Single-word packets, three words streamed.
    tbl.push_back(mk(1, 1, 32'hC1, 1, 1, 4'b0000, 32'h00, 8'd0));
    tbl.push_back(mk(0, 1, 32'hC2, 1, 1, 4'b1111, 32'hC1, 8'd1));
    tbl.push_back(mk(0, 1, 32'hC3, 1, 1, 4'b0000, 32'hC1, 8'd1));
    tbl.push_back(mk(0, 0, 32'h00, 1, 1, 4'b1111, 32'hC2, 8'd2));
    tbl.push_back(mk(0, 0, 32'h00, 1, 1, 4'b0000, 32'hC2, 8'd2));
    tbl.push_back(mk(0, 0, 32'h00, 1, 1, 4'b1111, 32'hC3, 8'd3));
    tbl.push_back(mk(0, 0, 32'h00, 1, 1, 4'b0000, 32'hC3, 8'd3));

    model_reset();
    apply_reset(1);

    foreach (tbl[i]) begin
      if (tbl[i].do_reset) apply_reset(0);
      step(tbl[i].v, tbl[i].d, tbl[i].en, tbl[i].len);
      check($sformatf("vec%0d_flags", i),
            {data_valid, start_of_packet, end_of_packet, busy}, tbl[i].e_flags);
      check($sformatf("vec%0d_data", i),  packet_data_out, tbl[i].e_data);
      check($sformatf("vec%0d_count", i), packet_count,    tbl[i].e_cnt);
    end

    // Underrun: source stalls two cycles after the second word.
    apply_reset(0);
    bubbles = 0;
    in_pkt  = 0;
    step(1, 32'hA1, 1, 4);
    step(1, 32'hA2, 1, 4);
    in_pkt = start_of_packet;
    step(0, 32'h0, 1, 4);
    step(0, 32'h0, 1, 4);
    if (in_pkt && !data_valid) bubbles++;
    step(1, 32'hA3, 1, 4);
    if (in_pkt && !data_valid) bubbles++;
    step(1, 32'hA4, 1, 4);
    step(0, 32'h0, 1, 4);
    check("underrun_bubbles", bubbles, 2);
    check("underrun_count_2", underrun_count, 4'd2);
    check("underrun_eop_4th", {data_valid, end_of_packet}, 2'b11);
    check("underrun_eop_data", packet_data_out, 32'hA4);

    // Backpressure: enable low, offer six words, then release with pkt_len=6.
    apply_reset(0);
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      acc = in_ready;
      step(sent < 6, 32'hB000_0000 + sent, 0, 6);
      if (acc && sent < 6) sent++;
    end
    check("bp_accepted_4", sent, 4);
    check("bp_in_ready_low", in_ready, 1'b0);
    got.delete();
    done = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      acc = in_ready;
      step(sent < 6, 32'hB000_0000 + sent, 1, 6);
      if (acc && sent < 6) sent++;
      if (data_valid) got.push_back(packet_data_out);
      if (end_of_packet) done = 1;
    end
    check("bp_eop_seen", done, 1'b1);
    check("bp_words_out", got.size(), 6);
    foreach (got[i]) check($sformatf("bp_word%0d", i), got[i], 32'hB000_0000 + i);
    check("bp_in_ready_back", in_ready, 1'b1);

    // Controls changed mid-packet: pkt_len 3 -> 8 and enable dropped.
    apply_reset(0);
    n_dv = 0; n_sop = 0; n_eop = 0; sent = 0;
    for (int c = 0; c < 14; c++) begin
      acc = in_ready;
      step(1, 32'hD000_0000 + sent, (c < 2), (c < 2) ? 4'd3 : 4'd8);
      if (acc) sent++;
      n_dv  += int'(data_valid);
      n_sop += int'(start_of_packet);
      n_eop += int'(end_of_packet);
    end
    check("ctl_words", n_dv, 3);
    check("ctl_sops", n_sop, 1);
    check("ctl_eops", n_eop, 1);

    // Reset asserted mid-packet: outputs clear at once, no end_of_packet.
    apply_reset(0);
    step(1, 32'hE1, 1, 5);
    step(1, 32'hE2, 1, 5);
    step(1, 32'hE3, 1, 5);
    check("mid_in_packet", busy, 1'b1);
    apply_reset(1);
    for (int c = 0; c < 4; c++) step(0, 32'h0, 1, 5);

    // Randomized run against the model.
    apply_reset(0);
    len_r = 4'd3;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 19) == 0) len_r = 4'($urandom_range(0, 15));
      step($urandom_range(0, 99) < 65, $urandom, $urandom_range(0, 9) != 0, len_r);
    end

    // packet_count wrap after 256 single-word packets.
    apply_reset(0);
    dut_eops = 0;
    for (int c = 0; c < 800 && dut_eops < 256; c++) begin
      step(1, 32'(c), 1, 1);
      dut_eops += int'(end_of_packet);
    end
    check("wrap_eops", dut_eops, 256);
    check("wrap_count_zero", packet_count, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
